rvc_fetch_aligner: RTL and testbench
====================================

Name: rvc_fetch_aligner

Overview:
Instruction fetch/realignment stage sitting directly upstream of the smartcard_2 core's decode input. It fetches aligned 32-bit words from instruction memory and buffers them as halfwords. It presents one instruction at a time, either a 16-bit RV32C instruction or a 32-bit instruction that may straddle a word boundary, together with its PC and a compressed flag. It also handles control-flow redirects, including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC after reset; must be halfword aligned.
QDEPTH_HW, 4, halfword queue depth; fixed at 4 (sizing assumption below).

Ports:
clk_sc  input  1  clock, rising edge.
resetn  input  1  asynchronous active-low reset.
mem_req  output  1  fetch request; held high until mem_ready.
mem_addr  output  32  word address, [1:0]=00; stable while mem_req=1.
mem_ready  input  1  response strobe; mem_rdata is valid in the same cycle.
mem_rdata  input  32  fetched word (little-endian halfwords).
redirect  input  1  single-cycle flush and restart.
redirect_pc  input  32  new PC; bit0 ignored.
instr_valid  output  1  instruction available.
instr_ready  input  1  consumer accepts.
instr_out  output  32  instruction; compressed instructions are zero-extended {16'h0, hw}.
instr_pc  output  32  PC of instr_out.
instr_rvc  output  1  1 = 16-bit instruction.

Behaviour:
- Reset (async, resetn=0):
  - Outputs: mem_req=0, mem_addr={RESET_PC[31:2],2'b00}, instr_valid=0, instr_out=0, instr_pc=RESET_PC, instr_rvc=0.
  - Internal: queue count=0, FSM=IDLE, skip_lo=RESET_PC[1].
- Queue: 4 halfwords, count 0..4, hw0 = oldest. The head PC is tracked in a register.
- Fetch FSM states IDLE, REQ, DROP; all outputs are registered.
  - IDLE: if count<=2, go to REQ next cycle (mem_req=1, mem_addr=fetch_addr).
  - REQ, on mem_ready:
    - Push both halfwords, or only the upper halfword if skip_lo=1.
    - Clear skip_lo; fetch_addr += 4.
    - Stay in REQ (back-to-back) if the post-push/pop count is <=2, else go to IDLE.
  - REQ, redirect without mem_ready: go to DROP. mem_req stays high, since a request is never withdrawn.
  - DROP: on mem_ready, discard the data and go to REQ at the new fetch_addr the next cycle.
- Only a fetch pushes, and it is issued only when count<=2, so overflow is impossible. Overflow is a verification assertion.
- Output selection (combinational from the queue, registered to the outputs is not required):
  - count>=1 and hw0[1:0]!=2'b11: instr_valid=1, instr_rvc=1, instr_out={16'h0,hw0}.
  - hw0[1:0]==2'b11: valid only when count>=2; instr_out={hw1,hw0}, instr_rvc=0.
  - Otherwise instr_valid=0. instr_out/instr_rvc may hold stale values while invalid.
- Consume on instr_valid & instr_ready: pop 1 or 2 halfwords; head PC += 2 or 4. A pop and a push in the same cycle are both applied.
- instr_valid/instr_out/instr_pc stay stable while instr_valid=1 and instr_ready=0 (no redirect).
- Redirect (highest priority):
  - Effects: queue flushed (count=0); head PC = {redirect_pc[31:1],1'b0}; fetch_addr = {redirect_pc[31:2],2'b00}; skip_lo = redirect_pc[1].
  - instr_valid=0 from the next cycle until the new data arrives.
  - Any consume or mem_ready data in the same cycle is ignored.
  - Redirect in REQ with mem_ready in the same cycle: data dropped, next state REQ at the new address (not DROP).
  - Redirect in DROP: update the target, remain in DROP.
- Minimum latency: redirect at cycle N, mem_req at N+1, zero-wait mem_ready at N+1, instr_valid at N+2.
- PC and address arithmetic is modulo 2^32; fetch_addr wraps from 0xFFFF_FFFC to 0.

Test Plan:
- Memory and ready setup: memory {0x0:0x00500093, 0x4:0x05054585, 0x8:0x05134501, 0xC:0x00010000}; zero-wait memory; instr_ready=1 after reset release. Required output sequence (pc:instr/rvc):
  - 0x0:0x00500093/0
  - 0x4:0x00004585/1
  - 0x6:0x00000505/1
  - 0x8:0x00004501/1
  - 0xA:0x00000513/0 (straddles words)
  - 0xE:0x00000001/1
- Backpressure: same image, instr_ready=0 for 10 cycles. instr_valid=1 stable with 0x00500093 at pc 0x0; exactly 2 fetches (0x0, 0x4); mem_req=0 thereafter.
- Redirect: pulse redirect with redirect_pc=0x6 while running. Next mem_addr=0x4; first valid output is pc 0x6, 0x00000505, rvc=1; the halfword at 0x4 is never presented.
- Redirect during an outstanding request: memory latency 3 cycles, redirect to 0x8 one cycle after mem_req rises. mem_req stays high and mem_addr unchanged until mem_ready; the stale word is never output; the next mem_addr is 0x8; the first output is pc 0x8, 0x00004501.
- Simultaneous events: redirect to 0x0 in the same cycle as mem_ready and instr_valid&instr_ready. The data is dropped, the head PC does not advance by the consume, and the next output is pc 0x0, 0x00500093.
- Reset mid-fetch: drop resetn while mem_req=1. All outputs take their reset values immediately, without a clock edge. After release, the first mem_addr is 0x0.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : rvc_fetch_aligner
// Brief    : Word fetch + halfword queue that presents one RV32C/RV32I
//            instruction at a time, with PC, and handles redirects.
// Revision : 1.0 - initial release
// ============================================================================
module rvc_fetch_aligner #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH_HW = 4
) (
    input  logic        clk_sc,
    input  logic        resetn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] instr_pc,
    output logic        instr_rvc
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_DROP = 2'd2;

    // A new fetch may only start when a full word still fits in the queue.
    localparam logic [2:0] c_REFILL_MAX = 3'(QDEPTH_HW - 2);

    logic [1:0]  r_state;
    logic [2:0]  r_count;
    logic [15:0] r_q [0:3];
    logic [31:0] r_head_pc;
    logic [31:0] r_fetch_addr;
    logic        r_skip_lo;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;

    logic        w_hw0_is32;
    logic        w_valid;
    logic        w_fire;
    logic        w_resp;
    logic [2:0]  w_pop;
    logic [2:0]  w_push;
    logic [2:0]  w_base;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] w_fa_nxt;
    logic [15:0] w_q_nxt [0:3];
    logic [1:0]  w_state_nxt;
    logic        w_req_nxt;
    logic [31:0] w_addr_nxt;
    logic        w_unused;

    assign w_unused   = redirect_pc[0];

    assign w_hw0_is32 = (r_q[0][1:0] == 2'b11);
    assign w_valid    = w_hw0_is32 ? (r_count >= 3'd2) : (r_count >= 3'd1);
    assign w_fire     = w_valid & instr_ready & ~redirect;
    assign w_resp     = (r_state == c_REQ) & mem_ready & ~redirect;
    assign w_pop      = !w_fire ? 3'd0 : (w_hw0_is32 ? 3'd2 : 3'd1);
    assign w_push     = !w_resp ? 3'd0 : (r_skip_lo ? 3'd1 : 3'd2);
    assign w_base     = r_count - w_pop;
    assign w_cnt_nxt  = redirect ? 3'd0 : (w_base + w_push);
    assign w_fa_nxt   = redirect ? {redirect_pc[31:2], 2'b00}
                      : w_resp   ? r_fetch_addr + 32'd4
                      :            r_fetch_addr;

    // Pop from the head first, then append the response behind what remains.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_q_nxt[i] = r_q[i];
        end
        if (w_pop == 3'd1) begin
            for (int i = 0; i < 3; i++) begin
                w_q_nxt[i] = r_q[i+1];
            end
        end else if (w_pop == 3'd2) begin
            w_q_nxt[0] = r_q[2];
            w_q_nxt[1] = r_q[3];
        end
        if (w_resp) begin
            for (int i = 0; i < 4; i++) begin
                if (r_skip_lo) begin
                    if (3'(i) == w_base) w_q_nxt[i] = mem_rdata[31:16];
                end else begin
                    if (3'(i) == w_base)        w_q_nxt[i] = mem_rdata[15:0];
                    if (3'(i) == w_base + 3'd1) w_q_nxt[i] = mem_rdata[31:16];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_mem_req;
        w_addr_nxt  = r_mem_addr;
        case (r_state)
            c_IDLE: begin
                if (w_cnt_nxt <= c_REFILL_MAX) begin
                    w_state_nxt = c_REQ;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = w_fa_nxt;
                end
            end
            c_REQ: begin
                if (mem_ready) begin
                    if (w_cnt_nxt <= c_REFILL_MAX) begin
                        w_addr_nxt = w_fa_nxt;
                    end else begin
                        w_state_nxt = c_IDLE;
                        w_req_nxt   = 1'b0;
                    end
                end else if (redirect) begin
                    // The request cannot be withdrawn; swallow its response.
                    w_state_nxt = c_DROP;
                end
            end
            c_DROP: begin
                if (mem_ready) begin
                    w_state_nxt = c_REQ;
                    w_addr_nxt  = w_fa_nxt;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sc or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_IDLE;
            r_count      <= 3'd0;
            r_head_pc    <= RESET_PC;
            r_fetch_addr <= {RESET_PC[31:2], 2'b00};
            r_skip_lo    <= RESET_PC[1];
            r_mem_req    <= 1'b0;
            r_mem_addr   <= {RESET_PC[31:2], 2'b00};
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= 16'h0000;
            end
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_cnt_nxt;
            r_fetch_addr <= w_fa_nxt;
            r_mem_req    <= w_req_nxt;
            r_mem_addr   <= w_addr_nxt;
            for (int i = 0; i < 4; i++) begin
                r_q[i] <= w_q_nxt[i];
            end
            if (redirect) begin
                r_head_pc <= {redirect_pc[31:1], 1'b0};
                r_skip_lo <= redirect_pc[1];
            end else begin
                if (w_fire) r_head_pc <= r_head_pc + (w_hw0_is32 ? 32'd4 : 32'd2);
                if (w_resp) r_skip_lo <= 1'b0;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = w_valid;
    assign instr_rvc   = w_valid & ~w_hw0_is32;
    assign instr_pc    = r_head_pc;
    assign instr_out   = !w_valid   ? 32'h0
                       : w_hw0_is32 ? {r_q[1], r_q[0]}
                       :              {16'h0000, r_q[0]};

endmodule
`default_nettype wire

// File: tb/tb_rvc_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvc_fetch_aligner
// Brief    : Scoreboard bench for rvc_fetch_aligner with a latency-programmable
//            word memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvc_fetch_aligner;

    logic        clk_sc = 1'b0;
    logic        resetn = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        instr_rvc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rvc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   lat   = 0;
    int   wcnt;
    int   fetch_cnt = 0;

    rvc_fetch_aligner #(.RESET_PC(32'h0), .QDEPTH_HW(4)) dut (
        .clk_sc      (clk_sc),
        .resetn      (resetn),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_rvc   (instr_rvc)
    );

    always #5 clk_sc = ~clk_sc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0505_4585;
            32'h8:   return 32'h0513_4501;
            32'hC:   return 32'h0001_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    always @(posedge clk_sc or negedge resetn) begin
        if (!resetn)                    wcnt <= 0;
        else if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end
    assign mem_ready = mem_req && (wcnt == lat);
    assign mem_rdata = mem_word(mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk_sc) begin
        if (resetn && mem_req && mem_ready) fetch_cnt++;
        if (resetn && instr_valid && instr_ready && !redirect && sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("sb_pc",  instr_pc,  mon_e.pc);
            chk("sb_ins", instr_out, mon_e.ins);
            chk("sb_rvc", {31'b0, instr_rvc}, {31'b0, mon_e.rvc});
        end
    end

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins, input logic rvc);
        exp_t e;
        e.pc = pc; e.ins = ins; e.rvc = rvc;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_sc);
        #1;
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_sc);
        #1;
        fetch_cnt = 0;
        resetn    = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 100 && sb.size() > 0; i++) step();
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!mem_req && n < 50) begin
            step();
            n++;
        end
        chk(tag, {31'b0, mem_req}, 32'd1);
    endtask

    initial begin
        logic [31:0] addr0;
        logic [31:0] out0;
        int          unstable;
        int          n;
        bit          seen;

        // Reset values, visible without any clock edge
        #2 resetn = 1'b0;
        #1;
        chk("rst_mem_req",  {31'b0, mem_req},     32'd0);
        chk("rst_mem_addr", mem_addr,             32'h0);
        chk("rst_valid",    {31'b0, instr_valid}, 32'd0);
        chk("rst_out",      instr_out,            32'h0);
        chk("rst_pc",       instr_pc,             32'h0);
        chk("rst_rvc",      {31'b0, instr_rvc},   32'd0);

        // Straight-line sequence with a straddling 32-bit instruction
        lat = 0;
        do_reset();
        push_exp(32'h0, 32'h0050_0093, 1'b0);
        push_exp(32'h4, 32'h0000_4585, 1'b1);
        push_exp(32'h6, 32'h0000_0505, 1'b1);
        push_exp(32'h8, 32'h0000_4501, 1'b1);
        push_exp(32'hA, 32'h0000_0513, 1'b0);
        push_exp(32'hE, 32'h0000_0001, 1'b1);
        instr_ready = 1'b1;
        drain("seq_drain");

        // Backpressure: queue fills and fetching stops
        do_reset();
        unstable = 0;
        seen     = 1'b0;
        out0     = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (instr_valid && !seen) begin
                seen = 1'b1;
                out0 = instr_out;
            end else if (seen && (!instr_valid || instr_out !== out0 || instr_pc !== 32'h0)) begin
                unstable++;
            end
        end
        chk("bp_valid",  {31'b0, instr_valid}, 32'd1);
        chk("bp_out",    instr_out,            32'h0050_0093);
        chk("bp_pc",     instr_pc,             32'h0);
        chk("bp_stable", 32'(unstable),        32'd0);
        chk("bp_fetch",  32'(fetch_cnt),       32'd2);
        chk("bp_req",    {31'b0, mem_req},     32'd0);

        // Redirect into the upper halfword of a word while running
        do_reset();
        instr_ready = 1'b1;
        repeat (4) step();
        redirect    = 1'b1;
        redirect_pc = 32'h6;
        push_exp(32'h6, 32'h0000_0505, 1'b1);
        push_exp(32'h8, 32'h0000_4501, 1'b1);
        step();
        redirect = 1'b0;
        chk("rd_req",   {31'b0, mem_req},     32'd1);
        chk("rd_addr",  mem_addr,             32'h4);
        chk("rd_inval", {31'b0, instr_valid}, 32'd0);
        step();
        chk("rd_lat",   {31'b0, instr_valid}, 32'd1);
        drain("rd_drain");

        // Redirect while a slow request is outstanding
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        wait_req("out_req_rise");
        addr0 = mem_addr;
        step();
        redirect    = 1'b1;
        redirect_pc = 32'h8;
        push_exp(32'h8, 32'h0000_4501, 1'b1);
        push_exp(32'hA, 32'h0000_0513, 1'b0);
        n = 0;
        unstable = 0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            step();
            redirect = 1'b0;
            if (!mem_req || mem_addr !== addr0) unstable++;
            if (mem_ready) seen = 1'b1;
            n++;
        end
        chk("out_ready_seen", {31'b0, seen}, 32'd1);
        chk("out_hold",       32'(unstable), 32'd0);
        step();
        chk("out_req_next",  {31'b0, mem_req}, 32'd1);
        chk("out_addr_next", mem_addr,         32'h8);
        drain("out_drain");

        // Redirect coinciding with a memory response and a consume
        lat = 0;
        do_reset();
        instr_ready = 1'b1;
        n = 0;
        step();
        while (!(instr_valid && mem_ready) && n < 20) begin
            step();
            n++;
        end
        chk("sim_found", {31'b0, instr_valid & mem_ready}, 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        push_exp(32'h0, 32'h0050_0093, 1'b0);
        push_exp(32'h4, 32'h0000_4585, 1'b1);
        step();
        redirect = 1'b0;
        chk("sim_inval", {31'b0, instr_valid}, 32'd0);
        chk("sim_pc",    instr_pc,             32'h0);
        chk("sim_req",   {31'b0, mem_req},     32'd1);
        chk("sim_addr",  mem_addr,             32'h0);
        drain("sim_drain");

        // Asynchronous reset in the middle of a fetch
        lat = 3;
        do_reset();
        instr_ready = 1'b1;
        repeat (12) step();
        wait_req("mr_req");
        #2 resetn = 1'b0;
        #1;
        chk("mr_mem_req",  {31'b0, mem_req},     32'd0);
        chk("mr_mem_addr", mem_addr,             32'h0);
        chk("mr_valid",    {31'b0, instr_valid}, 32'd0);
        chk("mr_out",      instr_out,            32'h0);
        chk("mr_pc",       instr_pc,             32'h0);
        chk("mr_rvc",      {31'b0, instr_rvc},   32'd0);
        step();
        step();
        resetn = 1'b1;
        wait_req("mr_req2");
        chk("mr_addr2", mem_addr, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
